// File: rtl/new_sub_module_pipe.sv
// Two-stage multiply-add / threshold-select datapath with a saturating running sum of out1.
// Latency: a beat accepted in cycle N is presented on out1/out2 in cycle N+2.
// Backpressure: in_ready = !out_valid || out_ready; both stages freeze while the output is stalled.
module new_sub_module_pipe #(
    parameter int W      = 4,
    parameter int K      = 3,
    parameter int THRESH = 2,
    parameter int ACCW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in1,
    input  logic [W-1:0]    in2,
    input  logic [W-1:0]    in3,
    input  logic            acc_en,
    input  logic            acc_clr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out1,
    output logic [W-1:0]    out2,
    output logic [ACCW-1:0] acc,
    output logic            acc_sat
);

    // Full-precision width of K*in3*in1; cannot overflow for any operand values.
    localparam int PW = 2*W + $clog2(K+1);

    logic            advance;

    // Stage 1 registers
    logic            s1_valid_q;
    logic [PW-1:0]   s1_prod_q;
    logic [W-1:0]    s1_in2_q;
    logic            s1_gt_q;
    logic [W-1:0]    s1_sum_q;
    logic [W-1:0]    s1_xor_q;
    logic            s1_acc_en_q;

    // Stage 1 next-state
    logic [PW-1:0]   s1_prod_d;
    logic            s1_gt_d;
    logic [W-1:0]    s1_sum_d;
    logic [W-1:0]    s1_xor_d;

    // Output stage
    logic            out_valid_q;
    logic [W-1:0]    out1_q;
    logic [W-1:0]    out2_q;
    logic [W-1:0]    out1_d;
    logic [W-1:0]    out2_d;

    // Accumulator
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] acc_d;
    logic            acc_sat_q;
    logic            acc_sat_d;
    logic [ACCW:0]   acc_sum;
    logic            acc_beat;

    // The whole pipe moves only when the output register is empty or being drained.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // Stage 1 datapath: full product, both candidate out2 values and the select bit.
    always_comb begin
        s1_prod_d = PW'(in1) * PW'(in3) * PW'(K);
        s1_gt_d   = ($unsigned(32'(in1)) > $unsigned(32'(THRESH)));
        s1_sum_d  = in2 + in3;
        s1_xor_d  = in2 ^ in3;
    end

    // Stage 1 register: operands are loaded unconditionally on advance; only s1_valid_q qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_in2_q    <= '0;
            s1_gt_q     <= 1'b0;
            s1_sum_q    <= '0;
            s1_xor_q    <= '0;
            s1_acc_en_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            s1_prod_q   <= s1_prod_d;
            s1_in2_q    <= in2;
            s1_gt_q     <= s1_gt_d;
            s1_sum_q    <= s1_sum_d;
            s1_xor_q    <= s1_xor_d;
            s1_acc_en_q <= acc_en;
        end
    end

    // Stage 2 datapath: final add wraps to W bits; out2 picks the registered candidate.
    always_comb begin
        out1_d = W'(PW'(s1_in2_q) + s1_prod_q);
        out2_d = s1_gt_q ? s1_sum_q : s1_xor_q;
    end

    // Output register: data only updates with a real beat so it holds across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            out2_q      <= '0;
        end else if (advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out1_q <= out1_d;
                out2_q <= out2_d;
            end
        end
    end

    // Accumulate the out1 value being loaded this cycle, so acc and its beat appear together.
    always_comb begin
        acc_beat  = advance && s1_valid_q && s1_acc_en_q;
        acc_sum   = {1'b0, acc_q} + (ACCW+1)'(out1_d);
        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;
        if (acc_clr) begin
            acc_d     = acc_beat ? ACCW'(out1_d) : '0;
            acc_sat_d = 1'b0;
        end else if (acc_beat) begin
            if (acc_sum[ACCW]) begin
                acc_d     = '1;
                acc_sat_d = 1'b1;
            end else begin
                acc_d     = acc_sum[ACCW-1:0];
            end
        end
    end

    // Accumulator state; clear is honoured even while the pipe is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out1      = out1_q;
    assign out2      = out2_q;
    assign acc       = acc_q;
    assign acc_sat   = acc_sat_q;

endmodule
